// File: rtl/flag_pkg.sv
// flag_pkg
// Shared definitions for the flag save/restore block:
//   CF, SF, ZF        - bit positions of the flags inside the flag vector
//   NFLAGS_DEFAULT    - default flag count
//   DEPTH_DEFAULT     - default number of save-stack entries
//   stack_op_e        - operation requested from the LIFO by the top level
package flag_pkg;

  localparam int CF = 0;
  localparam int SF = 1;
  localparam int ZF = 2;

  localparam int NFLAGS_DEFAULT = 3;
  localparam int DEPTH_DEFAULT  = 4;

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_XCHG = 2'd3
  } stack_op_e;

endpackage

// File: rtl/flag_lifo.sv
// flag_lifo
// Register-array LIFO for saved flag vectors. The caller only issues
// operations that are legal for the current occupancy; no bounds checks here.
// Ports:
//   clk, rst   - clock and synchronous active-high reset (count only)
//   op         - OP_IDLE / OP_PUSH / OP_POP / OP_XCHG
//   wr_data    - value written on push, or into the top entry on exchange
//   top        - entry at count-1, or zero when empty
//   count      - occupied entries, 0..DEPTH
module flag_lifo
  import flag_pkg::*;
#(
  parameter int W     = NFLAGS_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  stack_op_e       op,
  input  logic [W-1:0]    wr_data,
  output logic [W-1:0]    top,
  output logic [CW-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  // Push writes the slot at count; pop and exchange act on count-1.
  // Both indices stay below DEPTH whenever they are actually used.
  assign wr_idx = AW'(count);
  assign rd_idx = AW'(count - CW'(1));

  // Entries at or above count are stale and must never reach flags_out.
  assign top = (count != '0) ? mem[rd_idx] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      case (op)
        OP_PUSH: count <= count + CW'(1);
        OP_POP:  count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      case (op)
        OP_PUSH: mem[wr_idx] <= wr_data;
        OP_XCHG: mem[rd_idx] <= wr_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/flag_stack_register.sv
// flag_stack_register
// Flag register with per-flag write enables and a save/restore stack.
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   flags_in    - new flag values from the ALU
//   flag_we     - per-flag write enable
//   push, pop   - save / restore flags (both together = exchange with top)
//   err_clr     - clears the sticky ovf/unf flags
//   flags_out   - current registered flags
//   full, empty - stack occupancy status, decoded from the registered count
//   count       - occupied stack entries
//   ovf, unf    - sticky overflow (push while full) / underflow (pop while empty)
module flag_stack_register
  import flag_pkg::*;
#(
  parameter int NFLAGS = NFLAGS_DEFAULT,
  parameter int DEPTH  = DEPTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NFLAGS-1:0]            flags_in,
  input  logic [NFLAGS-1:0]            flag_we,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         err_clr,
  output logic [NFLAGS-1:0]            flags_out,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         ovf,
  output logic                         unf
);

  localparam int CW = $clog2(DEPTH + 1);

  stack_op_e          op;
  logic               apply_we;
  logic               load_top;
  logic               set_ovf;
  logic               set_unf;
  logic [NFLAGS-1:0]  top;
  logic [NFLAGS-1:0]  flags_next;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Priority decode. A successful pop or exchange owns flags_out for the
  // cycle, so flag_we is dropped; every other case still applies flag_we.
  always_comb begin
    op       = OP_IDLE;
    apply_we = 1'b1;
    load_top = 1'b0;
    set_ovf  = 1'b0;
    set_unf  = 1'b0;
    if (push && pop) begin
      if (!empty) begin
        op       = OP_XCHG;
        apply_we = 1'b0;
        load_top = 1'b1;
      end else begin
        set_unf  = 1'b1;
      end
    end else if (push) begin
      if (!full) begin
        op      = OP_PUSH;
      end else begin
        set_ovf = 1'b1;
      end
    end else if (pop) begin
      if (!empty) begin
        op       = OP_POP;
        apply_we = 1'b0;
        load_top = 1'b1;
      end else begin
        set_unf  = 1'b1;
      end
    end
  end

  always_comb begin
    flags_next = flags_out;
    if (load_top) begin
      flags_next = top;
    end else if (apply_we) begin
      flags_next = (flags_in & flag_we) | (flags_out & ~flag_we);
    end
  end

  // The stack always receives the pre-edge flags_out.
  flag_lifo #(
    .W     (NFLAGS),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_lifo (
    .clk     (clk),
    .rst     (rst),
    .op      (op),
    .wr_data (flags_out),
    .top     (top),
    .count   (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_out <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      flags_out <= flags_next;
      // A new error in the same cycle as err_clr keeps the flag set.
      if (set_ovf)      ovf <= 1'b1;
      else if (err_clr) ovf <= 1'b0;
      if (set_unf)      unf <= 1'b1;
      else if (err_clr) unf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_flag_stack_register.sv
// tb_flag_stack_register
// Scoreboard bench: each stimulus cycle pushes its expected outputs to a
// queue; the observed outputs after the edge are queued and compared per task.
module tb_flag_stack_register;

  localparam int NFLAGS = 3;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [NFLAGS-1:0] flags;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              ovf;
    logic              unf;
  } obs_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NFLAGS-1:0] flags_in;
  logic [NFLAGS-1:0] flag_we;
  logic              push;
  logic              pop;
  logic              err_clr;
  logic [NFLAGS-1:0] flags_out;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic              ovf;
  logic              unf;

  int checks = 0;
  int errors = 0;

  obs_t  exp_q[$];
  obs_t  got_q[$];
  string name_q[$];

  flag_stack_register #(.NFLAGS(NFLAGS), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flags_in  (flags_in),
    .flag_we   (flag_we),
    .push      (push),
    .pop       (pop),
    .err_clr   (err_clr),
    .flags_out (flags_out),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .ovf       (ovf),
    .unf       (unf)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic obs_t mk(input logic [NFLAGS-1:0] f, input int c,
                              input logic o, input logic u);
    obs_t e;
    e.flags = f;
    e.count = CW'(c);
    e.full  = (c == DEPTH);
    e.empty = (c == 0);
    e.ovf   = o;
    e.unf   = u;
    return e;
  endfunction

  // One clock of stimulus; records expectation and the post-edge outputs.
  task automatic cyc(input logic r, input logic [NFLAGS-1:0] fi,
                     input logic [NFLAGS-1:0] we, input logic pu,
                     input logic po, input logic cl,
                     input string nm, input obs_t e);
    rst = r; flags_in = fi; flag_we = we; push = pu; pop = po; err_clr = cl;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    got_q.push_back({flags_out, count, full, empty, ovf, unf});
  endtask

  task automatic test_reset();
    cyc(1, 3'b111, 3'b111, 1, 0, 0, "reset", mk(3'b000, 0, 0, 0));
    cyc(1, 3'b000, 3'b000, 0, 1, 1, "reset_hold", mk(3'b000, 0, 0, 0));
    while (exp_q.size() > 0) begin
      obs_t e = exp_q.pop_front();
      obs_t g = got_q.pop_front();
      string n = name_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s: got flags=%b count=%0d full=%b empty=%b ovf=%b unf=%b, expected flags=%b count=%0d full=%b empty=%b ovf=%b unf=%b",
                 n, g.flags, g.count, g.full, g.empty, g.ovf, g.unf,
                 e.flags, e.count, e.full, e.empty, e.ovf, e.unf);
      end
    end
  endtask

  task automatic test_flag_write();
    cyc(0, 3'b111, 3'b101, 0, 0, 0, "we_101", mk(3'b101, 0, 0, 0));
    cyc(0, 3'b010, 3'b000, 0, 0, 0, "we_000_hold", mk(3'b101, 0, 0, 0));
    cyc(0, 3'b010, 3'b011, 0, 0, 0, "we_011", mk(3'b110, 0, 0, 0));
    cyc(0, 3'b101, 3'b111, 0, 0, 0, "we_111", mk(3'b101, 0, 0, 0));
    while (exp_q.size() > 0) begin
      obs_t e = exp_q.pop_front();
      obs_t g = got_q.pop_front();
      string n = name_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s: got flags=%b count=%0d full=%b empty=%b ovf=%b unf=%b, expected flags=%b count=%0d full=%b empty=%b ovf=%b unf=%b",
                 n, g.flags, g.count, g.full, g.empty, g.ovf, g.unf,
                 e.flags, e.count, e.full, e.empty, e.ovf, e.unf);
      end
    end
  endtask

  task automatic test_push_pop();
    cyc(0, 3'b000, 3'b000, 1, 0, 0, "push", mk(3'b101, 1, 0, 0));
    cyc(0, 3'b010, 3'b111, 0, 0, 0, "write_010", mk(3'b010, 1, 0, 0));
    cyc(0, 3'b111, 3'b111, 0, 1, 0, "pop_ignores_we", mk(3'b101, 0, 0, 0));
    // push still applies flag_we but saves the pre-edge flags
    cyc(0, 3'b000, 3'b001, 1, 0, 0, "push_with_we", mk(3'b100, 1, 0, 0));
    cyc(0, 3'b000, 3'b000, 0, 1, 0, "pop_restore", mk(3'b101, 0, 0, 0));
    while (exp_q.size() > 0) begin
      obs_t e = exp_q.pop_front();
      obs_t g = got_q.pop_front();
      string n = name_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s: got flags=%b count=%0d full=%b empty=%b ovf=%b unf=%b, expected flags=%b count=%0d full=%b empty=%b ovf=%b unf=%b",
                 n, g.flags, g.count, g.full, g.empty, g.ovf, g.unf,
                 e.flags, e.count, e.full, e.empty, e.ovf, e.unf);
      end
    end
  endtask

  task automatic test_fill_overflow();
    cyc(0, 3'b001, 3'b111, 1, 0, 0, "fill_1", mk(3'b001, 1, 0, 0));
    cyc(0, 3'b010, 3'b111, 1, 0, 0, "fill_2", mk(3'b010, 2, 0, 0));
    cyc(0, 3'b011, 3'b111, 1, 0, 0, "fill_3", mk(3'b011, 3, 0, 0));
    cyc(0, 3'b100, 3'b111, 1, 0, 0, "fill_4_full", mk(3'b100, 4, 0, 0));
    cyc(0, 3'b110, 3'b111, 1, 0, 0, "push_full_ovf", mk(3'b110, 4, 1, 0));
    cyc(0, 3'b000, 3'b000, 0, 0, 1, "clr_ovf", mk(3'b110, 4, 0, 0));
    cyc(0, 3'b000, 3'b000, 1, 0, 1, "clr_vs_set", mk(3'b110, 4, 1, 0));
    cyc(0, 3'b000, 3'b000, 0, 0, 1, "clr_ovf_2", mk(3'b110, 4, 0, 0));
    cyc(0, 3'b000, 3'b000, 0, 1, 0, "drain_1", mk(3'b011, 3, 0, 0));
    cyc(0, 3'b000, 3'b000, 0, 1, 0, "drain_2", mk(3'b010, 2, 0, 0));
    cyc(0, 3'b000, 3'b000, 0, 1, 0, "drain_3", mk(3'b001, 1, 0, 0));
    cyc(0, 3'b000, 3'b000, 0, 1, 0, "drain_4", mk(3'b101, 0, 0, 0));
    while (exp_q.size() > 0) begin
      obs_t e = exp_q.pop_front();
      obs_t g = got_q.pop_front();
      string n = name_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s: got flags=%b count=%0d full=%b empty=%b ovf=%b unf=%b, expected flags=%b count=%0d full=%b empty=%b ovf=%b unf=%b",
                 n, g.flags, g.count, g.full, g.empty, g.ovf, g.unf,
                 e.flags, e.count, e.full, e.empty, e.ovf, e.unf);
      end
    end
  endtask

  task automatic test_underflow_exchange();
    cyc(0, 3'b000, 3'b000, 0, 1, 0, "pop_empty_unf", mk(3'b101, 0, 0, 1));
    cyc(0, 3'b000, 3'b100, 0, 1, 0, "pop_empty_we", mk(3'b001, 0, 0, 1));
    cyc(0, 3'b000, 3'b000, 0, 0, 1, "clr_unf", mk(3'b001, 0, 0, 0));
    cyc(0, 3'b111, 3'b010, 1, 1, 0, "xchg_empty_unf", mk(3'b011, 0, 0, 1));
    cyc(0, 3'b000, 3'b000, 0, 0, 1, "clr_unf_2", mk(3'b011, 0, 0, 0));
    cyc(0, 3'b100, 3'b111, 1, 0, 0, "push_top_011", mk(3'b100, 1, 0, 0));
    cyc(0, 3'b000, 3'b111, 1, 1, 0, "xchg", mk(3'b011, 1, 0, 0));
    cyc(0, 3'b000, 3'b000, 0, 1, 0, "pop_after_xchg", mk(3'b100, 0, 0, 0));
    while (exp_q.size() > 0) begin
      obs_t e = exp_q.pop_front();
      obs_t g = got_q.pop_front();
      string n = name_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s: got flags=%b count=%0d full=%b empty=%b ovf=%b unf=%b, expected flags=%b count=%0d full=%b empty=%b ovf=%b unf=%b",
                 n, g.flags, g.count, g.full, g.empty, g.ovf, g.unf,
                 e.flags, e.count, e.full, e.empty, e.ovf, e.unf);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    cyc(0, 3'b000, 3'b000, 0, 1, 0, "pre_unf", mk(3'b100, 0, 0, 1));
    cyc(0, 3'b001, 3'b111, 1, 0, 0, "pre_push_1", mk(3'b001, 1, 0, 1));
    cyc(0, 3'b010, 3'b111, 1, 0, 0, "pre_push_2", mk(3'b010, 2, 0, 1));
    cyc(0, 3'b011, 3'b111, 1, 0, 0, "pre_push_3", mk(3'b011, 3, 0, 1));
    cyc(1, 3'b111, 3'b111, 1, 0, 0, "reset_mid_push", mk(3'b000, 0, 0, 0));
    // stale entries must not reach flags_out after reset
    cyc(0, 3'b000, 3'b000, 0, 1, 0, "pop_after_reset", mk(3'b000, 0, 0, 1));
    while (exp_q.size() > 0) begin
      obs_t e = exp_q.pop_front();
      obs_t g = got_q.pop_front();
      string n = name_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s: got flags=%b count=%0d full=%b empty=%b ovf=%b unf=%b, expected flags=%b count=%0d full=%b empty=%b ovf=%b unf=%b",
                 n, g.flags, g.count, g.full, g.empty, g.ovf, g.unf,
                 e.flags, e.count, e.full, e.empty, e.ovf, e.unf);
      end
    end
  endtask

  initial begin
    rst = 1'b1; flags_in = '0; flag_we = '0; push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_flag_write();
    test_push_pop();
    test_fill_overflow();
    test_underflow_exchange();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
